// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Round-robin grant, operands held on the ALU bus, result routed back after WAIT_CYCLES.
module alu_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [7:0] OPA0,
    input  logic [7:0] OPB0,
    input  logic [7:0] OPA1,
    input  logic [7:0] OPB1,
    input  logic [2:0] SEL0,
    input  logic [2:0] SEL1,
    output logic       ACK0,
    output logic       ACK1,
    output logic       DONE0,
    output logic       DONE1,
    output logic [7:0] RESULT0,
    output logic [7:0] RESULT1,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT,
    output logic       BUSY
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic [3:0] count;
    logic       last;
    logic       owner;
    logic       bad_op;

    logic       pick;
    logic [7:0] pick_a;
    logic [7:0] pick_b;
    logic [2:0] pick_sel;
    logic [7:0] cap;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick = 1'b0;
        if (REQ0 && REQ1)
            pick = ~last;
        else if (REQ1)
            pick = 1'b1;
        pick_a   = pick ? OPA1 : OPA0;
        pick_b   = pick ? OPB1 : OPB0;
        pick_sel = pick ? SEL1 : SEL0;
        cap      = bad_op ? 8'h00 : ALU_RESULT;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            count      <= 4'd0;
            last       <= 1'b1;
            owner      <= 1'b0;
            bad_op     <= 1'b0;
            ACK0       <= 1'b0;
            ACK1       <= 1'b0;
            DONE0      <= 1'b0;
            DONE1      <= 1'b0;
            RESULT0    <= 8'h00;
            RESULT1    <= 8'h00;
            ALU_DATA1  <= 8'h00;
            ALU_DATA2  <= 8'h00;
            ALU_SELECT <= 3'd0;
            BUSY       <= 1'b0;
        end else begin
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
            DONE0 <= 1'b0;
            DONE1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        owner  <= pick;
                        last   <= pick;
                        ACK0   <= ~pick;
                        ACK1   <= pick;
                        // Opcodes 1xx are accepted but leave the ALU bus untouched.
                        bad_op <= pick_sel[2];
                        if (!pick_sel[2]) begin
                            ALU_DATA1  <= pick_a;
                            ALU_DATA2  <= pick_b;
                            ALU_SELECT <= pick_sel;
                        end
                        count <= WAIT_LD;
                        state <= EXEC;
                        BUSY  <= 1'b1;
                    end
                end
                EXEC: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        if (owner) begin
                            RESULT1 <= cap;
                            DONE1   <= 1'b1;
                        end else begin
                            RESULT0 <= cap;
                            DONE0   <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a
// schedule-level reference model. dut_a uses WAIT_CYCLES=1, dut_b WAIT_CYCLES=3.
module tb_alu_arbiter;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] opa0 = 8'h00, opb0 = 8'h00, opa1 = 8'h00, opb1 = 8'h00;
    logic [2:0] sel0 = 3'd0, sel1 = 3'd0;

    logic       ack0, ack1, done0, done1, busy;
    logic [7:0] res0, res1, d1, d2, ares;
    logic [2:0] asel;

    logic       ack0_b, ack1_b, done0_b, done1_b, busy_b;
    logic [7:0] res0_b, res1_b, d1_b, d2_b, ares_b;
    logic [2:0] asel_b;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd0:    return b;
            3'd1:    return a + b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb ares   = alu_f(asel, d1, d2);
    always_comb ares_b = alu_f(asel_b, d1_b, d2_b);

    alu_arbiter #(.WAIT_CYCLES(1)) dut_a (
        .CLK(CLK), .RESET(rst), .REQ0(req0), .REQ1(req1),
        .OPA0(opa0), .OPB0(opb0), .OPA1(opa1), .OPB1(opb1), .SEL0(sel0), .SEL1(sel1),
        .ACK0(ack0), .ACK1(ack1), .DONE0(done0), .DONE1(done1),
        .RESULT0(res0), .RESULT1(res1),
        .ALU_DATA1(d1), .ALU_DATA2(d2), .ALU_SELECT(asel), .ALU_RESULT(ares),
        .BUSY(busy)
    );

    alu_arbiter #(.WAIT_CYCLES(3)) dut_b (
        .CLK(CLK), .RESET(rst), .REQ0(req0), .REQ1(req1),
        .OPA0(opa0), .OPB0(opb0), .OPA1(opa1), .OPB1(opb1), .SEL0(sel0), .SEL1(sel1),
        .ACK0(ack0_b), .ACK1(ack1_b), .DONE0(done0_b), .DONE1(done1_b),
        .RESULT0(res0_b), .RESULT1(res1_b),
        .ALU_DATA1(d1_b), .ALU_DATA2(d2_b), .ALU_SELECT(asel_b), .ALU_RESULT(ares_b),
        .BUSY(busy_b)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 1'b1; opa0 = 8'h03; opb0 = 8'h01; sel0 = 3'd1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({ack0, ack1, done0, done1, busy, res0, res1, d1, d2, asel} !== 40'd0) begin
                bad++;
                $display("FAIL reset_outs_a cyc%0d: got %h want 0", i,
                         {ack0, ack1, done0, done1, busy, res0, res1, d1, d2, asel});
            end
            total++;
            if ({ack0_b, ack1_b, done0_b, done1_b, busy_b, res0_b, res1_b, d1_b, d2_b, asel_b} !== 40'd0) begin
                bad++;
                $display("FAIL reset_outs_b cyc%0d: got %h want 0", i,
                         {ack0_b, ack1_b, done0_b, done1_b, busy_b, res0_b, res1_b, d1_b, d2_b, asel_b});
            end
        end
        rst = 1'b0;
        step();
        total++;
        if ({ack0, ack1, busy, ack0_b} !== 4'b1011) begin
            bad++;
            $display("FAIL reset_first_grant: got %b want 1011", {ack0, ack1, busy, ack0_b});
        end
        req0 = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_single_add();
        do_reset();
        req0 = 1'b1; opa0 = 8'h03; opb0 = 8'h01; sel0 = 3'd1;
        step();
        req0 = 1'b0;
        total++;
        if ({ack0, ack1, done0, d1, d2, asel} !== {3'b100, 8'h03, 8'h01, 3'd1}) begin
            bad++;
            $display("FAIL add_grant: got %h want %h", {ack0, ack1, done0, d1, d2, asel},
                     {3'b100, 8'h03, 8'h01, 3'd1});
        end
        step();
        total++;
        if ({ack0, done0, done1, res0, res1} !== {3'b010, 8'h04, 8'h00}) begin
            bad++;
            $display("FAIL add_done: got %h want %h", {ack0, done0, done1, res0, res1},
                     {3'b010, 8'h04, 8'h00});
        end
        step();
        total++;
        if ({done0, res0} !== {1'b0, 8'h04}) begin
            bad++;
            $display("FAIL add_done_pulse: got %h want %h", {done0, res0}, {1'b0, 8'h04});
        end
    endtask

    task automatic test_round_robin();
        int first;
        int prev;
        int n;
        bit got0, got1;
        do_reset();
        opa0 = 8'h03; opb0 = 8'h01; sel0 = 3'd2;
        opa1 = 8'h02; opb1 = 8'h05; sel1 = 3'd3;
        req0 = 1'b1; req1 = 1'b1;
        first = -1; got0 = 0; got1 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done0 && !got0) begin
                got0 = 1; req0 = 1'b0;
                if (first < 0) first = 0;
                total++;
                if (res0 !== 8'h01) begin
                    bad++;
                    $display("FAIL rr_res0: got %h want 01", res0);
                end
            end
            if (done1 && !got1) begin
                got1 = 1; req1 = 1'b0;
                if (first < 0) first = 1;
                total++;
                if ({res1, res0} !== {8'h07, 8'h01}) begin
                    bad++;
                    $display("FAIL rr_res1: got %h want 0701", {res1, res0});
                end
            end
        end
        total++;
        if ({got0, got1} !== 2'b11 || first != 0) begin
            bad++;
            $display("FAIL rr_order: got done0=%0d done1=%0d first=%0d want 1 1 0", got0, got1, first);
        end
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        prev = 1; n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (ack0 || ack1) begin
                total++;
                if ((ack0 && ack1) || (int'(ack1) == prev)) begin
                    bad++;
                    $display("FAIL rr_alternate: got ack1=%0d ack0=%0d prev=%0d", ack1, ack0, prev);
                end
                prev = int'(ack1);
                n++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (n != 5) begin
            bad++;
            $display("FAIL rr_grant_count: got %0d want 5", n);
        end
    endtask

    task automatic test_bad_opcode();
        do_reset();
        req1 = 1'b1; opa1 = 8'h0F; opb1 = 8'hF0; sel1 = 3'd3;
        step();
        req1 = 1'b0;
        step();
        total++;
        if ({done1, res1} !== {1'b1, 8'hFF}) begin
            bad++;
            $display("FAIL badop_setup: got %h want %h", {done1, res1}, {1'b1, 8'hFF});
        end
        repeat (2) step();
        req1 = 1'b1; opa1 = 8'hAA; opb1 = 8'h55; sel1 = 3'b101;
        step();
        req1 = 1'b0;
        total++;
        if ({ack0, ack1, d1, d2, asel} !== {2'b01, 8'h0F, 8'hF0, 3'd3}) begin
            bad++;
            $display("FAIL badop_grant: got %h want %h", {ack0, ack1, d1, d2, asel},
                     {2'b01, 8'h0F, 8'hF0, 3'd3});
        end
        step();
        total++;
        if ({done0, done1, res1, res0, asel} !== {2'b01, 8'h00, 8'h00, 3'd3}) begin
            bad++;
            $display("FAIL badop_done: got %h want %h", {done0, done1, res1, res0, asel},
                     {2'b01, 8'h00, 8'h00, 3'd3});
        end
    endtask

    task automatic test_wait3();
        logic [2:0] exp;
        do_reset();
        req0 = 1'b1; opa0 = 8'h03; opb0 = 8'h01; sel0 = 3'd0;
        for (int k = 0; k < 6; k++) begin
            step();
            req0 = 1'b0;
            exp = {k == 0, k == 3, k <= 3};
            total++;
            if ({ack0_b, done0_b, busy_b} !== exp) begin
                bad++;
                $display("FAIL wait3_timing E%0d: got %b want %b", k, {ack0_b, done0_b, busy_b}, exp);
            end
        end
        total++;
        if ({res0_b, res1_b} !== {8'h01, 8'h00}) begin
            bad++;
            $display("FAIL wait3_result: got %h want 0100", {res0_b, res1_b});
        end
    endtask

    task automatic test_reset_in_exec();
        bit seen;
        do_reset();
        req0 = 1'b1; opa0 = 8'h03; opb0 = 8'h01; sel0 = 3'd1;
        step();
        req0 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({busy, busy_b, done0, done0_b} !== 4'b0000) begin
            bad++;
            $display("FAIL rstexec_abort: got %b want 0000", {busy, busy_b, done0, done0_b});
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done0 || done1 || done0_b || done1_b || busy || busy_b) seen = 1;
        end
        total++;
        if (seen || {res0, res0_b} !== 16'h0000) begin
            bad++;
            $display("FAIL rstexec_quiet: got activity=%0d res=%h want 0 0000", seen, {res0, res0_b});
        end
    endtask

    // Reference model works on the transaction schedule: a grant at edge g
    // frees the block for a new grant at g+W+2 and delivers its result at g+W.
    task automatic test_random();
        localparam int W = 1;
        int free_at, g_edge, g_own, last, w;
        logic [7:0] m_res[2];
        logic [7:0] g_val, m_d1, m_d2;
        logic [2:0] m_sel, s;
        logic [1:0] e_ack, e_done;
        logic       e_busy;
        do_reset();
        free_at = 0; g_edge = -100; g_own = 0; last = 1; g_val = 8'h00;
        m_res[0] = 8'h00; m_res[1] = 8'h00;
        m_d1 = 8'h00; m_d2 = 8'h00; m_sel = 3'd0;
        for (int k = 0; k < 300; k++) begin
            req0 = ($urandom_range(0, 9) < 6);
            req1 = ($urandom_range(0, 9) < 6);
            opa0 = 8'($urandom); opb0 = 8'($urandom);
            opa1 = 8'($urandom); opb1 = 8'($urandom);
            sel0 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            sel1 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            if (k >= free_at && (req0 || req1)) begin
                w = (req0 && req1) ? 1 - last : (req1 ? 1 : 0);
                last = w; g_edge = k; g_own = w; free_at = k + W + 2;
                s = w ? sel1 : sel0;
                if (s < 3'd4) begin
                    m_d1 = w ? opa1 : opa0;
                    m_d2 = w ? opb1 : opb0;
                    m_sel = s;
                    g_val = alu_f(s, m_d1, m_d2);
                end else begin
                    g_val = 8'h00;
                end
            end
            if (k == g_edge + W) m_res[g_own] = g_val;
            e_ack  = (k == g_edge) ? (g_own ? 2'b10 : 2'b01) : 2'b00;
            e_done = (k == g_edge + W) ? (g_own ? 2'b10 : 2'b01) : 2'b00;
            e_busy = (k >= g_edge) && (k <= g_edge + W);
            step();
            total++;
            if ({ack1, ack0} !== e_ack) begin
                bad++;
                $display("FAIL rand_ack k=%0d: got %b want %b", k, {ack1, ack0}, e_ack);
            end
            total++;
            if ({done1, done0} !== e_done) begin
                bad++;
                $display("FAIL rand_done k=%0d: got %b want %b", k, {done1, done0}, e_done);
            end
            total++;
            if (busy !== e_busy) begin
                bad++;
                $display("FAIL rand_busy k=%0d: got %b want %b", k, busy, e_busy);
            end
            total++;
            if ({res1, res0} !== {m_res[1], m_res[0]}) begin
                bad++;
                $display("FAIL rand_result k=%0d: got %h want %h", k, {res1, res0}, {m_res[1], m_res[0]});
            end
            total++;
            if ({d1, d2, asel} !== {m_d1, m_d2, m_sel}) begin
                bad++;
                $display("FAIL rand_alu_bus k=%0d: got %h want %h", k, {d1, d2, asel}, {m_d1, m_d2, m_sel});
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_bad_opcode();
        test_wait3();
        test_reset_in_exec();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
